// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Fetch handshake, ALU control and status bundle for the control unit.
// Revision : 1.0
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int PC_W     = 8,
    parameter int OPCODE_W = 4
);
    logic                start;
    logic                fetch_ack;
    logic [OPCODE_W-1:0] instr;
    logic [PC_W-1:0]     jmp_target;
    logic                cf_in;
    logic                sf_in;
    logic                zf_in;
    logic                fetch_req;
    logic [PC_W-1:0]     pc;
    logic [1:0]          op;
    logic                imm_sel;
    logic                reg_en;
    logic                jmp_sel;
    logic [2:0]          flags;
    logic                halted;
    logic                err;

    modport slave (
        input  start, fetch_ack, instr, jmp_target, cf_in, sf_in, zf_in,
        output fetch_req, pc, op, imm_sel, reg_en, jmp_sel, flags, halted, err
    );

    modport master (
        output start, fetch_ack, instr, jmp_target, cf_in, sf_in, zf_in,
        input  fetch_req, pc, op, imm_sel, reg_en, jmp_sel, flags, halted, err
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : FETCH/DECODE/EXEC control unit owning the PC and latched flags.
// Revision : 1.0
// ============================================================================
module multicycle_control_unit #(
    parameter int PC_W          = 8,
    parameter int OPCODE_W      = 4,
    parameter int FETCH_TIMEOUT = 15
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    multicycle_control_unit_if.slave bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_HALT   = 3'd4;
    localparam logic [2:0] c_ERR    = 3'd5;

    localparam logic [7:0]      c_TIMEOUT = FETCH_TIMEOUT[7:0];
    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]          state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [2:0]          flags_q;
    logic [OPCODE_W-1:0] ir_q;
    logic [7:0]          cnt_q;
    logic [1:0]          dec_op_q;
    logic                dec_imm_q, dec_wr_q, dec_jmp_q, dec_flg_q, dec_hlt_q;

    logic [3:0] w_opc;
    logic [1:0] w_op;
    logic       w_imm, w_wr, w_jmp, w_flg, w_hlt, w_illegal;
    logic [7:0] w_cnt_inc;

    assign w_opc     = ir_q[3:0];
    assign w_cnt_inc = cnt_q + 8'd1;

    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign w_illegal = |ir_q[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign w_illegal = 1'b0;
        end
    endgenerate

    // Jump conditions read flags_q, which still holds the previous instruction's result.
    always_comb begin
        w_op  = 2'b00;
        w_imm = 1'b0;
        w_wr  = 1'b0;
        w_jmp = 1'b0;
        w_flg = 1'b0;
        w_hlt = 1'b0;
        if (!w_opc[3]) begin
            w_op  = w_opc[2:1];
            w_imm = w_opc[0];
            w_wr  = 1'b1;
            w_flg = 1'b1;
        end else begin
            case (w_opc[2:0])
                3'b000:  w_jmp = 1'b1;
                3'b001:  w_jmp = flags_q[0];
                3'b010:  w_jmp = flags_q[2];
                3'b011:  w_jmp = flags_q[1];
                3'b100:  w_jmp = ~flags_q[0];
                3'b110: begin
                    w_op  = 2'b01;
                    w_flg = 1'b1;
                end
                3'b111:  w_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (bus.start) state_d = c_FETCH;
            c_FETCH: begin
                if (bus.fetch_ack)             state_d = c_DECODE;
                else if (w_cnt_inc == c_TIMEOUT) state_d = c_ERR;
            end
            c_DECODE: state_d = w_illegal ? c_ERR : c_EXEC;
            c_EXEC:   state_d = dec_hlt_q ? c_HALT : c_FETCH;
            c_HALT:   if (bus.start) state_d = c_FETCH;
            c_ERR:    state_d = c_ERR;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        bus.fetch_req = (state_q == c_FETCH);
        bus.halted    = (state_q == c_HALT);
        bus.err       = (state_q == c_ERR);
        bus.op        = 2'b00;
        bus.imm_sel   = 1'b0;
        bus.reg_en    = 1'b0;
        bus.jmp_sel   = 1'b0;
        if (state_q == c_EXEC) begin
            bus.op      = dec_op_q;
            bus.imm_sel = dec_imm_q;
            bus.reg_en  = dec_wr_q;
            bus.jmp_sel = dec_jmp_q;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            flags_q   <= 3'b000;
            ir_q      <= '0;
            cnt_q     <= 8'd0;
            dec_op_q  <= 2'b00;
            dec_imm_q <= 1'b0;
            dec_wr_q  <= 1'b0;
            dec_jmp_q <= 1'b0;
            dec_flg_q <= 1'b0;
            dec_hlt_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == c_FETCH && !bus.fetch_ack) ? w_cnt_inc : 8'd0;
            if (state_q == c_FETCH && bus.fetch_ack) begin
                ir_q <= bus.instr;
            end
            if (state_q == c_DECODE) begin
                dec_op_q  <= w_op;
                dec_imm_q <= w_imm;
                dec_wr_q  <= w_wr;
                dec_jmp_q <= w_jmp;
                dec_flg_q <= w_flg;
                dec_hlt_q <= w_hlt;
            end
            if (state_q == c_EXEC) begin
                if (dec_flg_q) begin
                    flags_q <= {bus.cf_in, bus.sf_in, bus.zf_in};
                end
                pc_q <= dec_jmp_q ? bus.jmp_target : pc_q + c_PC_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    multicycle_control_unit_if #(.PC_W(8), .OPCODE_W(4)) bus ();

    multicycle_control_unit #(
        .PC_W(8),
        .OPCODE_W(4),
        .FETCH_TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Called at a negedge while in FETCH; returns at the negedge inside EXEC.
    task automatic issue(input logic [3:0] opc, input logic [7:0] tgt,
                         input logic c, input logic s, input logic z);
        bus.fetch_ack  = 1'b1;
        bus.instr      = opc;
        bus.jmp_target = tgt;
        bus.cf_in      = c;
        bus.sf_in      = s;
        bus.zf_in      = z;
        @(negedge clk);
        bus.fetch_ack  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.fetch_ack  = 1'b0;
        bus.instr      = 4'h0;
        bus.jmp_target = 8'h00;
        bus.cf_in      = 1'b0;
        bus.sf_in      = 1'b0;
        bus.zf_in      = 1'b0;
        #12;
        chk("rst_pc",        32'(bus.pc), 32'h0);
        chk("rst_fetch_req", 32'(bus.fetch_req), 32'h0);
        chk("rst_flags",     32'(bus.flags), 32'h0);
        chk("rst_halted",    32'(bus.halted), 32'h0);
        chk("rst_err",       32'(bus.err), 32'h0);
        chk("rst_reg_en",    32'(bus.reg_en), 32'h0);

        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("fetch_req_on", 32'(bus.fetch_req), 32'h1);
        bus.start = 1'b0;

        // ADD i with zf_in=1: first instruction, spelled out cycle by cycle
        bus.fetch_ack = 1'b1;
        bus.instr     = 4'b0001;
        bus.zf_in     = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("dec_reg_en",    32'(bus.reg_en), 32'h0);
        chk("dec_fetch_req", 32'(bus.fetch_req), 32'h0);
        @(negedge clk);
        chk("addi_op",     32'(bus.op), 32'h0);
        chk("addi_imm",    32'(bus.imm_sel), 32'h1);
        chk("addi_reg_en", 32'(bus.reg_en), 32'h1);
        @(negedge clk);
        chk("addi_pulse_end", 32'(bus.reg_en), 32'h0);
        chk("addi_flags",     32'(bus.flags), 32'h1);
        chk("addi_pc",        32'(bus.pc), 32'h1);
        chk("addi_refetch",   32'(bus.fetch_req), 32'h1);

        issue(4'b1110, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("cmp_op",     32'(bus.op), 32'h1);
        chk("cmp_reg_en", 32'(bus.reg_en), 32'h0);
        @(negedge clk);
        chk("cmp_pc", 32'(bus.pc), 32'h2);

        issue(4'b1001, 8'h40, 1'b0, 1'b0, 1'b0);
        chk("jz_taken", 32'(bus.jmp_sel), 32'h1);
        @(negedge clk);
        chk("jz_pc",    32'(bus.pc), 32'h40);
        chk("jz_flags", 32'(bus.flags), 32'h1);

        issue(4'b1110, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cmp0_flags", 32'(bus.flags), 32'h0);
        chk("cmp0_pc",    32'(bus.pc), 32'h41);

        issue(4'b1001, 8'h40, 1'b0, 1'b0, 1'b0);
        chk("jz_not_taken", 32'(bus.jmp_sel), 32'h0);
        @(negedge clk);
        chk("jz_nt_pc", 32'(bus.pc), 32'h42);

        issue(4'b1100, 8'h80, 1'b0, 1'b0, 1'b0);
        chk("jnz_taken", 32'(bus.jmp_sel), 32'h1);
        @(negedge clk);
        chk("jnz_pc", 32'(bus.pc), 32'h80);

        issue(4'b1001, 8'h40, 1'b0, 1'b0, 1'b0);
        bus.zf_in = 1'b1;
        chk("jz_live_flag_ignored", 32'(bus.jmp_sel), 32'h0);
        @(negedge clk);
        chk("jz_live_pc",    32'(bus.pc), 32'h81);
        chk("jz_live_flags", 32'(bus.flags), 32'h0);

        issue(4'b1000, 8'hFF, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("jmp_ff_pc",    32'(bus.pc), 32'hFF);
        chk("jmp_no_flags", 32'(bus.flags), 32'h0);
        issue(4'b1101, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("nop_reg_en", 32'(bus.reg_en), 32'h0);
        @(negedge clk);
        chk("pc_wrap", 32'(bus.pc), 32'h0);

        issue(4'b1000, 8'h05, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(4'b1111, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("hlt_jmp_sel", 32'(bus.jmp_sel), 32'h0);
        @(negedge clk);
        chk("halted",         32'(bus.halted), 32'h1);
        chk("halt_pc",        32'(bus.pc), 32'h6);
        chk("halt_fetch_req", 32'(bus.fetch_req), 32'h0);
        repeat (2) @(negedge clk);
        chk("halt_holds", 32'(bus.halted), 32'h1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("resume_fetch_req", 32'(bus.fetch_req), 32'h1);
        chk("resume_pc",        32'(bus.pc), 32'h6);
        chk("resume_halted",    32'(bus.halted), 32'h0);

        // ack arrives in the 15th FETCH cycle: still a success
        repeat (14) @(negedge clk);
        chk("late_ack_err",       32'(bus.err), 32'h0);
        chk("late_ack_fetch_req", 32'(bus.fetch_req), 32'h1);
        issue(4'b1101, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("late_ack_no_err", 32'(bus.err), 32'h0);
        @(negedge clk);
        chk("late_ack_pc", 32'(bus.pc), 32'h7);

        repeat (14) @(negedge clk);
        chk("to_pre_err", 32'(bus.err), 32'h0);
        @(negedge clk);
        chk("to_err",       32'(bus.err), 32'h1);
        chk("to_fetch_req", 32'(bus.fetch_req), 32'h0);
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        chk("err_sticky",      32'(bus.err), 32'h1);
        chk("err_no_fetch",    32'(bus.fetch_req), 32'h0);
        chk("err_pc_held",     32'(bus.pc), 32'h7);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_clears_err", 32'(bus.err), 32'h0);
        chk("rst_clears_pc",  32'(bus.pc), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        issue(4'b1101, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_add_pc", 32'(bus.pc), 32'h1);
        issue(4'b0000, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("addr_reg_en", 32'(bus.reg_en), 32'h1);
        chk("addr_imm",    32'(bus.imm_sel), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_reg_en", 32'(bus.reg_en), 32'h0);
        chk("abort_pc",     32'(bus.pc), 32'h0);
        chk("abort_flags",  32'(bus.flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pc",        32'(bus.pc), 32'h0);
        chk("post_rst_flags",     32'(bus.flags), 32'h0);
        chk("post_rst_fetch_req", 32'(bus.fetch_req), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
